// File: rtl/tdm_demultiplexer_if.sv
// tdm_demultiplexer_if: bundle of the serial input stream and 4-lane frame output of the TDM demultiplexer.
//   in_valid/in_ready/in_data/in_sof : serial sample stream, slot 0 marked by in_sof
//   out_valid/out_ready/out0..out3   : completed frame, lane k carries slot k
//   addr1,addr0                      : slot counter for the next sample to be accepted
//   sync_err                         : one-cycle framing error pulse
// master drives the stream and consumes frames; slave is the demultiplexer.
interface tdm_demultiplexer_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic             addr0;
  logic             addr1;
  logic             sync_err;
  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out0, out1, out2, out3, addr0, addr1, sync_err
  );
  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out0, out1, out2, out3, addr0, addr1, sync_err
  );
endinterface

// File: rtl/tdm_demultiplexer.sv
// tdm_demultiplexer: 4-lane TDM demultiplexer, routes slot k of a serial stream to lane k and
// presents each completed frame on a valid/ready output.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : tdm_demultiplexer_if.slave (input stream, frame output, slot counter, sync_err)
// Optional: define TDM_DEMUX_STRICT_SOF_EN to drop samples arriving at slot 0 without in_sof.
module tdm_demultiplexer #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                reset_n,
  tdm_demultiplexer_if.slave bus
);
  logic [1:0]            slot_q, slot_d, eff_slot;
  logic [2:0][WIDTH-1:0] stage_q, stage_d;
  logic [3:0][WIDTH-1:0] out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  sync_err_q, sync_err_d;
  logic                  in_ready, accept, resync, drop, store, complete;
  // Only the frame-completing sample can stall; earlier slots overlap with the held frame.
  assign in_ready = !(slot_q == 2'd3 && out_valid_q && !bus.out_ready);
  always_comb begin
    accept   = bus.in_valid && in_ready;
    // sof away from slot 0 abandons the partial frame and restarts at slot 0.
    resync   = accept && bus.in_sof && slot_q != 2'd0;
`ifdef TDM_DEMUX_STRICT_SOF_EN
    drop     = accept && !bus.in_sof && slot_q == 2'd0;
`else
    drop     = 1'b0;
`endif
    store    = accept && !drop;
    eff_slot = resync ? 2'd0 : slot_q;
    complete = store && eff_slot == 2'd3;
    slot_d   = store ? eff_slot + 2'd1 : slot_q;
    for (int k = 0; k < 3; k++)
      stage_d[k] = (store && eff_slot == 2'(k)) ? bus.in_data : stage_q[k];
    // Slot 3 bypasses staging straight into lane 3.
    out_d       = complete ? {bus.in_data, stage_q[2], stage_q[1], stage_q[0]} : out_q;
    out_valid_d = complete || (out_valid_q && !bus.out_ready);
    sync_err_d  = resync || drop;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q      <= '0;
      stage_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      stage_q     <= stage_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out0      = out_q[0];
  assign bus.out1      = out_q[1];
  assign bus.out2      = out_q[2];
  assign bus.out3      = out_q[3];
  assign bus.addr0     = slot_q[0];
  assign bus.addr1     = slot_q[1];
  assign bus.sync_err  = sync_err_q;
endmodule
